// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: memory geometry and the program loader state encoding.
package sap1_pkg;

  localparam int SAP1_ADDR_W = 4;
  localparam int SAP1_DATA_W = 8;
  localparam int SAP1_DEPTH  = 2 ** SAP1_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } ld_state_t;

endpackage

// File: rtl/prog_loader.sv
// Writes a byte stream into SAP-1 program memory, one mem_we 1 cycle after each handshake (max 1 byte / 2 cycles),
// holding the CPU in reset until the image is complete; in_ready only in LOAD. Optional checksum: PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import sap1_pkg::*;
#(
  parameter int ADDR_W = SAP1_ADDR_W,
  parameter int DATA_W = SAP1_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ld_state_t         r_state;
  ld_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_last;
  logic              w_hs;
  logic              w_start_acc;

  assign w_hs        = (r_state == ST_LOAD) && in_valid;
  assign w_start_acc = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_LOAD;
          w_cnt_nxt   = '0;
        end
      end
      ST_LOAD: begin
        if (in_valid) w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        // The last address ends the load even without in_last so the counter never wraps.
        if (r_last || (r_cnt == LAST_ADDR)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_LOAD;
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_last  <= 1'b0;
    end else if (w_hs) begin
      r_addr  <= r_cnt;
      r_wdata <= in_data;
      r_last  <= in_last;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum <= '0;
    end else if (w_start_acc) begin
      r_sum <= '0;
    end else if (r_state == ST_WRITE) begin
      r_sum <= r_sum + r_wdata;
    end
  end

  assign checksum = r_sum;
`else
  logic w_unused;
  assign w_unused = w_start_acc;
  assign checksum = '0;
`endif

  assign in_ready  = (r_state == ST_LOAD);
  assign mem_we    = (r_state == ST_WRITE);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign cpu_rst   = (r_state != ST_DONE);
  assign busy      = (r_state == ST_LOAD) || (r_state == ST_WRITE);
  assign done      = (r_state == ST_DONE);

endmodule
